// File: rtl/rs_tagged_issue_if.sv
// Dispatch, CDB and issue bundle for the tag-based reservation station.
// The master side drives dispatch/CDB/issue_ready; the slave side is the station itself.
interface rs_tagged_issue_if #(
   parameter int TAG_W     = 6,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 64,
   parameter int CNT_W     = 4
);
   logic                 flush;
   logic                 disp_valid;
   logic                 disp_ready;
   logic [PAYLOAD_W-1:0] disp_payload;
   logic [TAG_W-1:0]     disp_dest_tag;
   logic                 disp_src1_rdy;
   logic                 disp_src2_rdy;
   logic [TAG_W-1:0]     disp_src1_tag;
   logic [TAG_W-1:0]     disp_src2_tag;
   logic [DATA_W-1:0]    disp_src1_val;
   logic [DATA_W-1:0]    disp_src2_val;
   logic                 cdb_valid;
   logic [TAG_W-1:0]     cdb_tag;
   logic [DATA_W-1:0]    cdb_value;
   logic                 issue_valid;
   logic                 issue_ready;
   logic [PAYLOAD_W-1:0] issue_payload;
   logic [TAG_W-1:0]     issue_dest_tag;
   logic [DATA_W-1:0]    issue_src1_val;
   logic [DATA_W-1:0]    issue_src2_val;
   logic [CNT_W-1:0]     count;

   modport master (
      output flush, disp_valid, disp_payload, disp_dest_tag,
             disp_src1_rdy, disp_src2_rdy, disp_src1_tag, disp_src2_tag,
             disp_src1_val, disp_src2_val, cdb_valid, cdb_tag, cdb_value, issue_ready,
      input  disp_ready, issue_valid, issue_payload, issue_dest_tag,
             issue_src1_val, issue_src2_val, count
   );

   modport slave (
      input  flush, disp_valid, disp_payload, disp_dest_tag,
             disp_src1_rdy, disp_src2_rdy, disp_src1_tag, disp_src2_tag,
             disp_src1_val, disp_src2_val, cdb_valid, cdb_tag, cdb_value, issue_ready,
      output disp_ready, issue_valid, issue_payload, issue_dest_tag,
             issue_src1_val, issue_src2_val, count
   );
endinterface

// File: rtl/rs_tagged_issue.sv
// Tag-based reservation station: CDB wakeup, age-ordered (rank) select, flush.
// Optional macro RS_WAKEUP_BYPASS_EN enables same-cycle CDB-to-issue bypass.
module rs_tagged_issue #(
   parameter int DEPTH     = 8,
   parameter int TAG_W     = 6,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 64
) (
   input logic              clk,
   input logic              reset_n,
   rs_tagged_issue_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0]     valid_q;
   logic [DEPTH-1:0]     src1_rdy_q;
   logic [DEPTH-1:0]     src2_rdy_q;
   logic [TAG_W-1:0]     src1_tag_q [DEPTH];
   logic [TAG_W-1:0]     src2_tag_q [DEPTH];
   logic [DATA_W-1:0]    src1_val_q [DEPTH];
   logic [DATA_W-1:0]    src2_val_q [DEPTH];
   logic [TAG_W-1:0]     dest_tag_q [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
   logic [IDX_W-1:0]     rank_q     [DEPTH];
   logic [CNT_W-1:0]     count_q;

   logic [DEPTH-1:0]  src1_ok;
   logic [DEPTH-1:0]  src2_ok;
   logic              sel_found;
   logic [IDX_W-1:0]  sel_idx;
   logic [IDX_W-1:0]  sel_rank;
   logic              free_found;
   logic [IDX_W-1:0]  free_idx;
   logic [DATA_W-1:0] sel_src1_val;
   logic [DATA_W-1:0] sel_src2_val;
   logic              issue_fire;
   logic              disp_fire;
   logic              disp_src1_rdy_eff;
   logic              disp_src2_rdy_eff;

   always_comb begin
      src1_ok = '0;
      src2_ok = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
         src1_ok[i] = src1_rdy_q[i] | (bus.cdb_valid && (bus.cdb_tag == src1_tag_q[i]));
         src2_ok[i] = src2_rdy_q[i] | (bus.cdb_valid && (bus.cdb_tag == src2_tag_q[i]));
`else
         src1_ok[i] = src1_rdy_q[i];
         src2_ok[i] = src2_rdy_q[i];
`endif
      end
   end

   // Oldest ready entry wins; ranks of valid entries are unique so no tie-break needed.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      sel_rank   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && src1_ok[i] && src2_ok[i] && (!sel_found || rank_q[i] < sel_rank)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_rank  = rank_q[i];
         end
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      sel_src1_val = src1_val_q[sel_idx];
      sel_src2_val = src2_val_q[sel_idx];
`ifdef RS_WAKEUP_BYPASS_EN
      if (!src1_rdy_q[sel_idx]) sel_src1_val = bus.cdb_value;
      if (!src2_rdy_q[sel_idx]) sel_src2_val = bus.cdb_value;
`endif
   end

   assign bus.disp_ready     = (count_q != CNT_W'(DEPTH));
   assign bus.count          = count_q;
   assign bus.issue_valid    = sel_found;
   assign bus.issue_payload  = sel_found ? payload_q[sel_idx]  : '0;
   assign bus.issue_dest_tag = sel_found ? dest_tag_q[sel_idx] : '0;
   assign bus.issue_src1_val = sel_found ? sel_src1_val : '0;
   assign bus.issue_src2_val = sel_found ? sel_src2_val : '0;

   assign issue_fire = sel_found && bus.issue_ready && !bus.flush;
   assign disp_fire  = bus.disp_valid && bus.disp_ready && free_found && !bus.flush;

   assign disp_src1_rdy_eff = bus.disp_src1_rdy | (bus.cdb_valid && (bus.cdb_tag == bus.disp_src1_tag));
   assign disp_src2_rdy_eff = bus.disp_src2_rdy | (bus.cdb_valid && (bus.cdb_tag == bus.disp_src2_tag));

   // Wakeup, issue-free with rank compaction, and dispatch all resolve in one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= '0;
         src1_rdy_q <= '0;
         src2_rdy_q <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            src1_tag_q[i] <= '0;
            src2_tag_q[i] <= '0;
            src1_val_q[i] <= '0;
            src2_val_q[i] <= '0;
            dest_tag_q[i] <= '0;
            payload_q[i]  <= '0;
            rank_q[i]     <= '0;
         end
      end else if (bus.flush) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) rank_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !src1_rdy_q[i] && bus.cdb_valid && (bus.cdb_tag == src1_tag_q[i])) begin
               src1_rdy_q[i] <= 1'b1;
               src1_val_q[i] <= bus.cdb_value;
            end
            if (valid_q[i] && !src2_rdy_q[i] && bus.cdb_valid && (bus.cdb_tag == src2_tag_q[i])) begin
               src2_rdy_q[i] <= 1'b1;
               src2_val_q[i] <= bus.cdb_value;
            end
            if (issue_fire && (sel_idx == IDX_W'(i))) begin
               valid_q[i] <= 1'b0;
            end else if (issue_fire && valid_q[i] && (rank_q[i] > sel_rank)) begin
               rank_q[i] <= rank_q[i] - IDX_W'(1);
            end
         end
         if (disp_fire) begin
            valid_q[free_idx]    <= 1'b1;
            payload_q[free_idx]  <= bus.disp_payload;
            dest_tag_q[free_idx] <= bus.disp_dest_tag;
            src1_tag_q[free_idx] <= bus.disp_src1_tag;
            src2_tag_q[free_idx] <= bus.disp_src2_tag;
            src1_rdy_q[free_idx] <= disp_src1_rdy_eff;
            src2_rdy_q[free_idx] <= disp_src2_rdy_eff;
            src1_val_q[free_idx] <= bus.disp_src1_rdy ? bus.disp_src1_val : bus.cdb_value;
            src2_val_q[free_idx] <= bus.disp_src2_rdy ? bus.disp_src2_val : bus.cdb_value;
            rank_q[free_idx]     <= IDX_W'(count_q - CNT_W'(issue_fire));
         end
         count_q <= count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
      end
   end
endmodule

// File: doc/rs_tagged_issue.md
# rs_tagged_issue

Parametrised tag-based reservation station between dispatch and the functional units. It holds up to DEPTH instructions and captures source operands from a single common data bus (CDB) by physical tag. Each cycle it issues the oldest entry whose operands are both ready. It replaces the fixed 4-entry station and adds tag wakeup, age-ordered select, a valid/ready handshake on both sides, and flush.

## Interface
- DEPTH, 8, number of entries (≥2, power of two not required)
- TAG_W, 6, physical register tag width
- DATA_W, 32, operand/CDB value width
- PAYLOAD_W, 64, opaque instruction payload width (opcode, imm, PC, ...)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept (count < DEPTH)
- disp_payload  in  PAYLOAD_W  instruction payload
- disp_dest_tag  in  TAG_W  destination tag
- disp_src1_rdy / disp_src2_rdy  in  1  operand already available
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag when not ready
- disp_src1_val / disp_src2_val  in  DATA_W  operand value when ready
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  DATA_W  broadcast value
- issue_valid  out  1  an issueable entry is presented
- issue_ready  in  1  FU accepts
- issue_payload  out  PAYLOAD_W; issue_dest_tag  out  TAG_W; issue_src1_val / issue_src2_val  out  DATA_W
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry state: valid, src1/src2 {rdy, tag, val}, dest_tag, payload, rank (0 = oldest).
- Dispatch fires on disp_valid && disp_ready && !flush. Writes lowest-index free slot; rank = count minus 1 if an issue fires the same cycle, else count.
- Dispatch-cycle capture: if cdb_valid, a not-ready source and cdb_tag == src tag, the source is stored rdy=1, val=cdb_value.
- Wakeup: every valid entry with a not-ready source whose tag equals cdb_tag (cdb_valid=1) sets rdy and latches cdb_value. Already-ready sources ignore the CDB. One CDB may wake any number of entries/sources.
- Select: among valid entries with both sources ready, present the lowest rank. issue_* outputs are combinational from entry state (see Configuration).
- Issue fires on issue_valid && issue_ready. The entry is freed and every entry with a larger rank decrements rank. Ranks stay a dense 0..count-1 permutation.
- Outputs hold stable while issue_valid && !issue_ready, unless an older entry becomes ready. The selection may then change; the FU must not assume stability.
- flush: all valid cleared next edge. Dispatch and issue are ignored that cycle (issue_valid still displayed; a fire is discarded). count=0 next cycle.
- Full: disp_ready=0 when count==DEPTH, even if an issue fires that cycle. There is no combinational path from issue_ready to disp_ready.
- Empty: issue_valid=0.

## Timing
- Reset (reset_n=0, async): all valid=0, rank=0, count=0, disp_ready=1, issue_valid=0, issue_* data=0.
- Reset mid-operation drops all entries immediately; no issue is generated.
- Dispatch at edge t makes the entry selectable in cycle t+1 (earliest issue fire t+1).
- CDB in cycle t: without bypass, the woken entry is issueable in t+1; with bypass, in t.
- Simultaneous dispatch + issue + CDB in the same cycle are all legal and independent, apart from the rank rule above.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: select also treats a source as ready if cdb_valid && cdb_tag matches its tag in the current cycle. issue_srcN_val is muxed from cdb_value for that source. This gives zero-cycle wakeup-to-issue. If the entry fires in that cycle, it is freed without also latching.
- Not defined: select uses registered rdy bits only, so wakeup-to-issue is 1 cycle and issue_* has no CDB path.

## Test plan
- Reset/fill: reset_n low→high, dispatch 8 ready instrs with dest tags 1..8 and issue_ready=0 → count=8, disp_ready=0. Raise issue_ready → issue order dest 1..8, one per cycle, count back to 0.
- Wakeup: dispatch A with src1 tag 5 not ready, then B fully ready. CDB tag 5, value 0xDEAD → B issues first. A issues next cycle (same cycle with bypass) with src1_val=0xDEAD.
- Dispatch capture: dispatch src2 tag 9 not ready while CDB tag 9, value 0x1234 → entry issues next cycle with src2_val=0x1234.
- Age after out-of-order issue: dispatch tags 1,2,3 with 2 ready first, then wake 1 and 3 together → issue 2, then 1, then 3.
- Full + issue same cycle: count=8, issue fires, disp_valid=1 → dispatch refused (disp_ready=0). Next cycle count=7, disp_ready=1 and dispatch accepted.
- Flush/reset mid-op: 5 entries, flush=1 with disp_valid=1 and issue_ready=1 → next cycle count=0, issue_valid=0. Repeat with reset_n pulsed low mid-cycle → outputs at reset values immediately.
